add_serial_driver: RTL and testbench

//  Upstream sequencer for the 8-bit bit-serial adder (add_serial). Accepts operand

---
 rtl/add_serial_driver.sv | 87 ++++++++
 tb/tb_add_serial_driver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/add_serial_driver.sv
// Sequencer for the bit-serial adder: accepts operand pairs, pulses the adder's en
// through wake/launch, waits out the serial latency and returns the captured sum.
module add_serial_driver #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned WAIT_CYCLES = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_en,
  input  logic [WIDTH-1:0] add_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAKE,
    S_LAUNCH,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          primed;

  // Moore decode straight from the state register
  assign in_ready = (state == S_IDLE);
  assign add_en   = (state == S_WAKE) || (state == S_LAUNCH);
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (in_valid) state_nxt = primed ? S_WAKE : S_LAUNCH;
      S_WAKE:   state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (cnt == '0) state_nxt = S_RESULT;
      S_RESULT: if (res_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // An adder left in DONE (primed) needs one extra en pulse before it will load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      add_a     <= '0;
      add_b     <= '0;
      res_sum   <= '0;
      res_valid <= 1'b0;
      primed    <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && in_valid) begin
        add_a <= in_a;
        add_b <= in_b;
      end
      if (state == S_LAUNCH) begin
        cnt <= CW'(WAIT_CYCLES - 1);
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (state == S_WAIT && cnt == '0) begin
        res_sum   <= add_out;
        res_valid <= 1'b1;
        primed    <= 1'b1;
      end
      if (state == S_RESULT && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_add_serial_driver.sv
// Bench for add_serial_driver with a behavioural bit-serial adder attached; results
// are compared against plain (a+b) mod 256 and the expected handshake latency.
module tb_add_serial_driver;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned WAIT  = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_en;
  logic [WIDTH-1:0] add_out;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_sum;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int en_bad = 0;
  bit primed = 1'b0;

  add_serial_driver #(.WIDTH(WIDTH), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_en(add_en),
    .add_out(add_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural serial adder: IDLE -en-> ADD (one bit per cycle) -> DONE -en-> IDLE
  typedef enum {A_IDLE, A_ADD, A_DONE} adder_st_t;
  adder_st_t        ast;
  logic [WIDTH-1:0] ra, rb, acc;
  logic             carry;
  int               bi;

  assign add_out = acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ast <= A_IDLE; ra <= '0; rb <= '0; acc <= '0; carry <= 1'b0; bi <= 0;
    end else begin
      case (ast)
        A_IDLE: if (add_en) begin
          ra <= add_a; rb <= add_b; acc <= '0; carry <= 1'b0; bi <= 0; ast <= A_ADD;
        end
        A_ADD: begin
          acc[bi] <= ra[bi] ^ rb[bi] ^ carry;
          carry   <= (ra[bi] & rb[bi]) | (carry & (ra[bi] ^ rb[bi]));
          bi      <= bi + 1;
          if (bi == WIDTH - 1) ast <= A_DONE;
        end
        default: if (add_en) ast <= A_IDLE;
      endcase
    end
  end

  always @(negedge clk) if (rst && add_en && ast == A_ADD) en_bad++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One operation: accept, observe en pulses and latency, optionally stall the result
  task automatic op(input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [7:0] exp_sum;
    int  lat, ens, k;
    bit  got, rdy;
    exp_sum = 8'(a + b);
    rdy = 1'b0;
    for (int i = 0; i < 50 && !rdy; i++) begin
      @(negedge clk);
      rdy = in_ready;
    end
    if (!rdy) check("wait_in_ready", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
    lat = 0; ens = 0; got = 1'b0; k = 0;
    while (k < 40 && !got) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check("busy_after_accept", {30'd0, in_ready, busy}, 32'b01);
        check("add_ab_latched", {16'd0, add_a, add_b}, {16'd0, a, b});
      end
      if (add_en) ens++;
      if (res_valid) begin got = 1'b1; lat = k; end
    end
    if (!got) check("result_timeout", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(2 + WAIT + (primed ? 1 : 0)));
    check("en_cycles", 32'(ens), primed ? 32'd2 : 32'd1);
    check("res_sum", 32'(res_sum), 32'(exp_sum));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_stable", {21'd0, res_valid, in_ready, add_en, res_sum},
            {21'd0, 1'b1, 1'b0, 1'b0, exp_sum});
      check("hold_add_a", {16'd0, add_a, add_b}, {16'd0, a, b});
      in_valid = 1'($urandom_range(0, 1));
      in_a = 8'($urandom); in_b = 8'($urandom);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("release_ready", {30'd0, in_ready, res_valid}, 32'b10);
    primed = 1'b1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    int         hold;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{a: 8'h05, b: 8'h03, sum: 8'h08, hold: 0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, hold: 0};
    vecs[2] = '{a: 8'h3C, b: 8'h7B, sum: 8'hB7, hold: 20};
    vecs[3] = '{a: 8'hAA, b: 8'h55, sum: 8'hFF, hold: 0};
    vecs[4] = '{a: 8'h80, b: 8'h80, sum: 8'h00, hold: 0};

    repeat (3) @(negedge clk);
    check("reset_state", {5'd0, in_ready, busy, add_en, res_valid, res_sum, add_a, add_b},
          {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'd0});
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      check("table_model", 32'(8'(vecs[i].a + vecs[i].b)), 32'(vecs[i].sum));
      op(vecs[i].a, vecs[i].b, vecs[i].hold);
    end
    // The model entry above confirms the table; op() itself rechecks res_sum.

    // Reset in the middle of S_WAIT
    @(negedge clk);
    in_a = 8'h77; in_b = 8'h11; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", {30'd0, busy, add_en}, 32'b10);
    #2 rst = 1'b0;
    #1 check("mid_reset", {5'd0, in_ready, busy, add_en, res_valid, res_sum, add_a, add_b},
             {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'd0});
    primed = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    op(8'h12, 8'h34, 0);

    // Continuous in_valid with random res_ready
    begin
      logic [7:0] q[$];
      logic [7:0] pa, pb, e;
      int  sent, recv, cyc;
      bit  pend;
      sent = 0; recv = 0; cyc = 0; pend = 1'b0;
      @(negedge clk);
      pa = 8'($urandom); pb = 8'($urandom);
      in_a = pa; in_b = pb; in_valid = 1'b1;
      while (recv < 50 && cyc < 5000) begin
        if (pend) begin
          sent++; pend = 1'b0;
          if (sent < 50) begin
            pa = 8'($urandom); pb = 8'($urandom); in_a = pa; in_b = pb;
          end else in_valid = 1'b0;
        end
        res_ready = 1'($urandom_range(0, 1));
        if (in_valid && in_ready) begin q.push_back(8'(pa + pb)); pend = 1'b1; end
        if (res_valid && res_ready) begin
          if (q.size() == 0) check("rnd_extra_result", 32'd1, 32'd0);
          else begin
            e = q.pop_front();
            check("rnd_sum", 32'(res_sum), 32'(e));
          end
          recv++;
        end
        @(negedge clk);
        cyc++;
      end
      res_ready = 1'b0; in_valid = 1'b0;
      check("rnd_recv", 32'(recv), 32'd50);
      check("rnd_sent", 32'(sent), 32'd50);
      check("rnd_queue_empty", 32'(q.size()), 32'd0);
    end

    repeat (3) @(negedge clk);
    check("en_during_add", 32'(en_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
